// File: rtl/fg_cfg_writer.sv
// Writes the masked bytes of a 64-bit configuration image to a register-file generator
// with programmable setup / write-pulse / hold timing on a level write enable.
module fg_cfg_writer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [63:0] cfg_i,
  input  logic [7:0]  mask_i,
  output logic [7:0]  data_o,
  output logic [2:0]  addr_o,
  output logic        wr_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] cfg_q, cfg_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  addr_q, addr_d;
  logic        abort_seen_q, abort_seen_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_idx = 3'(i);
    end
  endfunction

  // CRn lives in the most-significant byte for n = 0.
  function automatic logic [7:0] cr_byte(input logic [63:0] cfg, input logic [2:0] n);
    logic [63:0] sh;
    sh = cfg >> {3'd7 - n, 3'b000};
    cr_byte = sh[7:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cfg_d        = cfg_q;
    mask_d       = mask_q;
    data_d       = data_q;
    addr_d       = addr_q;
    abort_seen_d = abort_seen_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cfg_d        = cfg_i;
          abort_seen_d = 1'b0;
          if (mask_i == 8'd0) begin
            mask_d  = 8'd0;
            state_d = DONE;
          end else begin
            addr_d  = lowest_idx(mask_i);
            data_d  = cr_byte(cfg_i, lowest_idx(mask_i));
            mask_d  = mask_i & ~(8'd1 << lowest_idx(mask_i));
            cnt_d   = SETUP_LAST;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (abort_i) begin
          abort_seen_d = 1'b1;
          state_d      = DONE;
        end else if (cnt_q == 8'd0) begin
          cnt_d   = PULSE_LAST;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PULSE: begin
        if (abort_i || cnt_q == 8'd0) begin
          abort_seen_d = abort_seen_q | abort_i;
          cnt_d        = HOLD_LAST;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        abort_seen_d = abort_seen_q | abort_i;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (abort_seen_d || mask_q == 8'd0) begin
          state_d = DONE;
        end else begin
          // Remaining mask only holds higher bits, so addresses ascend.
          addr_d  = lowest_idx(mask_q);
          data_d  = cr_byte(cfg_q, lowest_idx(mask_q));
          mask_d  = mask_q & ~(8'd1 << lowest_idx(mask_q));
          cnt_d   = SETUP_LAST;
          state_d = SETUP;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_d      = (state_d == PULSE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    aborted_d = (state_d == DONE) && abort_seen_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      cfg_q        <= 64'd0;
      mask_q       <= 8'd0;
      data_q       <= 8'd0;
      addr_q       <= 3'd0;
      abort_seen_q <= 1'b0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_q        <= cfg_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      abort_seen_q <= abort_seen_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign data_o    = data_q;
  assign addr_o    = addr_q;
  assign wr_en_o   = wr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;

endmodule

// File: tb/tb_fg_cfg_writer.sv
// Scoreboard bench for fg_cfg_writer: stimulus pushes planned writes/done events,
// a negedge monitor pops and compares them against what the pins show.
module tb_fg_cfg_writer;
  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 4;
  localparam int T = S + P + H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [63:0] cfg_i = 64'd0;
  logic [7:0]  mask_i = 8'd0;
  logic [7:0]  data_o;
  logic [2:0]  addr_o;
  logic        wr_en_o, busy_o, done_o, aborted_o;

  fg_cfg_writer #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .cfg_i(cfg_i), .mask_i(mask_i), .data_o(data_o), .addr_o(addr_o),
    .wr_en_o(wr_en_o), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] addr; logic [7:0] data; int width; } wr_t;
  typedef struct { int cyc; logic aborted; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference plan: the cycle "k+1" of the timing rule is the cycle that follows
  // start edge k, i.e. DONE is seen after edge k + done_off.
  task automatic plan(input logic [63:0] cfg, input logic [7:0] mask, input int abort_off,
                      input int k, output int done_off);
    int idx[$];
    int n_set, r, ph, full;
    logic ab;
    for (int n = 0; n < 8; n++) if (mask[n]) idx.push_back(n);
    n_set = idx.size();
    ab = 1'b0;
    full = n_set;
    done_off = n_set * T;
    if (abort_off >= 0 && abort_off < n_set * T) begin
      ab = 1'b1;
      r  = abort_off / T;
      ph = abort_off % T;
      if (ph < S) begin
        full = r;
        done_off = abort_off + 1;
      end else if (ph < S + P) begin
        full = r;
        done_off = abort_off + 1 + H;
      end else begin
        full = r + 1;
        done_off = (r + 1) * T;
      end
    end
    for (int i = 0; i < full; i++)
      wq.push_back('{addr: 3'(idx[i]), data: cfg[63 - 8*idx[i] -: 8], width: P});
    if (ab && full == r && ph >= S && ph < S + P)
      wq.push_back('{addr: 3'(idx[r]), data: cfg[63 - 8*idx[r] -: 8], width: ph - S + 1});
    dq.push_back('{cyc: k + done_off, aborted: ab});
  endtask

  // Monitor
  logic [7:0] prev_data, hold_data;
  logic [2:0] prev_addr, hold_addr;
  logic       prev_wr = 1'b0;
  int         stable = 0, hold_left = 0, width = 0;
  wr_t        cur;
  dn_t        dn;

  always @(negedge clk) begin
    if (!mon_en) begin
      hold_left = 0;
      stable = 0;
    end else begin
      if (data_o == prev_data && addr_o == prev_addr) stable++;
      else stable = 0;
      if (hold_left > 0) begin
        chk("hold_stable", {data_o, 5'd0, addr_o}, {hold_data, 5'd0, hold_addr});
        hold_left--;
      end
      if (wr_en_o && !prev_wr) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          cur = wq.pop_front();
          chk("write_addr", addr_o, cur.addr);
          chk("write_data", data_o, cur.data);
          chk("setup_ok", stable >= S, 1);
        end
        width = 1;
      end else if (wr_en_o) begin
        width++;
      end else if (prev_wr) begin
        chk("pulse_width", width, cur.width);
        chk("pulse_stable", stable >= S + width, 1);
        hold_data = data_o;
        hold_addr = addr_o;
        hold_left = H - 1;
      end
      if (done_o) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          dn = dq.pop_front();
          chk("done_cycle", cyc, dn.cyc);
          chk("aborted", aborted_o, dn.aborted);
        end
      end else if (aborted_o) begin
        chk("aborted_without_done", 1, 0);
      end
    end
    prev_wr   = wr_en_o;
    prev_data = data_o;
    prev_addr = addr_o;
  end

  task automatic run_seq(input logic [63:0] cfg, input logic [7:0] mask,
                         input int abort_off, input bit noise);
    int done_off, k;
    k = cyc + 1;
    plan(cfg, mask, abort_off, k, done_off);
    start_i = 1'b1;
    cfg_i   = cfg;
    mask_i  = mask;
    abort_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    for (int t = 0; t <= done_off; t++) begin
      abort_i = (t == abort_off) ? 1'b1 :
                ((t == done_off && noise) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (noise) begin
        start_i = ($urandom_range(0, 3) == 0);
        cfg_i   = {$urandom, $urandom};
        mask_i  = 8'($urandom);
      end
      tick();
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("idle_after_done", busy_o, 0);
    chk("writes_left", wq.size(), 0);
    chk("dones_left", dq.size(), 0);
    for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
      abort_i = 1'($urandom_range(0, 1));
      tick();
    end
    abort_i = 1'b0;
  endtask

  initial begin
    int dummy;
    logic [7:0] m;
    repeat (3) tick();
    chk("reset_outputs", {data_o, addr_o, wr_en_o, busy_o, done_o, aborted_o}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    run_seq(64'h0011223344556677, 8'hFF, -1, 1'b0);
    run_seq(64'h0011223344556677, 8'h00, -1, 1'b0);
    run_seq(64'hA1B2C3D4E5F60718, 8'b0100_0001, -1, 1'b1);
    run_seq(64'h0011223344556677, 8'hFF, 2*T + S + 1, 1'b0);
    run_seq(64'h0011223344556677, 8'hFF, -1, 1'b1);
    run_seq(64'h8899AABBCCDDEEFF, 8'h3C, 0, 1'b0);
    run_seq(64'h8899AABBCCDDEEFF, 8'h81, T - 1, 1'b0);

    // Reset in the second PULSE cycle of addr 4.
    start_i = 1'b1; cfg_i = 64'h0011223344556677; mask_i = 8'hFF;
    plan(cfg_i, mask_i, -1, cyc + 1, dummy);
    tick();
    start_i = 1'b0;
    for (int t = 0; t < 4*T + S + 1; t++) tick();
    chk("pulse_before_reset", {wr_en_o, addr_o}, {1'b1, 3'd4});
    mon_en = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_pulse_reset", {data_o, addr_o, wr_en_o, busy_o, done_o, aborted_o}, 0);
    wq.delete();
    dq.delete();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      abort_i = 1'($urandom_range(0, 1));
      tick();
    end
    abort_i = 1'b0;
    chk("idle_after_reset", {busy_o, wr_en_o}, 0);

    for (int i = 0; i < 40; i++) begin
      m = 8'($urandom);
      run_seq({$urandom, $urandom}, m,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, $countones(m) * T)) : -1,
              1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
